// File: rtl/sdram_wr_burst_fetch.sv
// rtl/sdram_wr_burst_fetch.sv - drains the SDRAM write FIFO in fixed or flushed bursts with a wrapping word address
module sdram_wr_burst_fetch #(
    parameter int     DATA_WIDTH = 16,
    parameter int     NUM_WIDTH  = 10,
    parameter int     BURST_LEN  = 8,
    parameter int     ADDR_WIDTH = 24,
    parameter longint ADDR_BASE  = 0,
    parameter longint ADDR_LIMIT = 2**24
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  flush_i,
    input  logic [NUM_WIDTH-1:0]  fifo_rd_use_num_i,
    output logic                  fifo_rd_req_o,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    output logic                  sdram_wr_req_o,
    input  logic                  sdram_wr_gnt_i,
    output logic [ADDR_WIDTH-1:0] sdram_wr_addr_o,
    output logic [NUM_WIDTH-1:0]  sdram_wr_len_o,
    output logic                  sdram_wr_vld_o,
    output logic [DATA_WIDTH-1:0] sdram_wr_data_o,
    output logic                  burst_done_o
);

    typedef enum logic [1:0] {IDLE, REQ, READ, LAST} state_e;

    localparam logic [NUM_WIDTH-1:0]  BURST_LEN_W = NUM_WIDTH'(BURST_LEN);
    localparam logic [NUM_WIDTH-1:0]  ONE_W       = NUM_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   LIMIT_W     = (ADDR_WIDTH+1)'(ADDR_LIMIT);
    localparam logic [ADDR_WIDTH:0]   BASE_W      = (ADDR_WIDTH+1)'(ADDR_BASE);

    state_e                state_q;
    logic [NUM_WIDTH-1:0]  len_q;
    logic [NUM_WIDTH-1:0]  cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [ADDR_WIDTH:0]   addr_sum;
    logic                  req_q;
    logic                  rd_req_q;
    logic                  vld_q;
    logic                  done_q;

    // One extra bit on the sum so a burst ending exactly at the top of the address space still wraps.
    always_comb begin
        addr_sum = {1'b0, addr_q} + (ADDR_WIDTH+1)'(len_q);
        addr_d   = addr_sum[ADDR_WIDTH-1:0];
        if (addr_sum >= LIMIT_W) begin
            addr_d = ADDR_WIDTH'(addr_sum - LIMIT_W + BASE_W);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            addr_q   <= ADDR_WIDTH'(ADDR_BASE);
            req_q    <= 1'b0;
            rd_req_q <= 1'b0;
            vld_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            vld_q  <= rd_req_q;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable_i && (fifo_rd_use_num_i >= BURST_LEN_W)) begin
                        len_q   <= BURST_LEN_W;
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end else if (enable_i && flush_i && (fifo_rd_use_num_i != '0)) begin
                        len_q   <= fifo_rd_use_num_i;
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (sdram_wr_gnt_i) begin
                        req_q    <= 1'b0;
                        rd_req_q <= 1'b1;
                        cnt_q    <= len_q;
                        state_q  <= READ;
                    end
                end
                READ: begin
                    // cnt_q is the number of pops still owed including the one happening now.
                    if (cnt_q > ONE_W) begin
                        cnt_q <= cnt_q - ONE_W;
                    end else begin
                        rd_req_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= LAST;
                    end
                end
                LAST: begin
                    addr_q  <= addr_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fifo_rd_req_o   = rd_req_q;
    assign sdram_wr_req_o  = req_q;
    assign sdram_wr_addr_o = addr_q;
    assign sdram_wr_len_o  = len_q;
    assign sdram_wr_vld_o  = vld_q;
    assign sdram_wr_data_o = vld_q ? fifo_rd_data_i : '0;
    assign burst_done_o    = done_q;

endmodule
